// File: rtl/trng_fetch_master.sv
// Host-side read master for the TRNG read port: raises paced read requests only while the
// FIFO holds data, captures each returned word onto a valid/ready stream and tracks burst progress.
module trng_fetch_master #(
    parameter int REQ_HIGH_CYCLES = 2,
    parameter int REQ_LOW_CYCLES  = 2,
    parameter int VALID_TIMEOUT   = 16,
    parameter int AVAIL_TIMEOUT   = 0,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             en_cfg,
    output logic             trng_enable,
    output logic             trng_read_req,
    input  logic [31:0]      trng_data,
    input  logic             trng_data_valid,
    input  logic             trng_fifo_empty,
    output logic [31:0]      m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] words_done
);

    localparam int HI_W = $clog2(REQ_HIGH_CYCLES + 2);
    localparam int LO_W = $clog2(REQ_LOW_CYCLES + 2);
    localparam int VT_W = $clog2(VALID_TIMEOUT + 2);
    localparam int AV_W = $clog2(AVAIL_TIMEOUT + 2);

    localparam logic [HI_W-1:0] HI_LAST = HI_W'(REQ_HIGH_CYCLES - 1);
    localparam logic [LO_W-1:0] LO_LAST = LO_W'(REQ_LOW_CYCLES - 1);
    localparam logic [VT_W-1:0] VT_LAST = VT_W'(VALID_TIMEOUT - 1);
    localparam logic [AV_W-1:0] AV_LAST = AV_W'((AVAIL_TIMEOUT == 0) ? 0 : AVAIL_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_AVAIL = 3'd1,
        S_REQ_HIGH   = 3'd2,
        S_REQ_LOW    = 3'd3,
        S_HOLD       = 3'd4,
        S_FIN        = 3'd5
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] words_q;
    logic [CNT_W-1:0] words_d;
    logic [HI_W-1:0]  hi_cnt_q;
    logic [LO_W-1:0]  lo_cnt_q;
    logic [VT_W-1:0]  vt_cnt_q;
    logic [AV_W-1:0]  av_cnt_q;
    logic             pending_q;
    logic             req_q;
    logic             en_q;
    logic [31:0]      m_data_q;
    logic             m_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             timeout_q;

    logic             accept;
    logic             capture;
    logic             vt_expired;

    // Stream handshake, word capture and response-timeout qualifiers
    always_comb begin
        accept     = m_valid_q & m_ready;
        capture    = pending_q & trng_data_valid;
        vt_expired = 1'b0;
        if (accept) begin
            words_d = words_q + CNT_W'(1);
        end else begin
            words_d = words_q;
        end
        if (pending_q && !trng_data_valid && (vt_cnt_q == VT_LAST)) begin
            vt_expired = 1'b1;
        end else begin
            vt_expired = 1'b0;
        end
    end

    // Burst sequencer with registered request, stream and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            len_q     <= {CNT_W{1'b0}};
            words_q   <= {CNT_W{1'b0}};
            hi_cnt_q  <= {HI_W{1'b0}};
            lo_cnt_q  <= {LO_W{1'b0}};
            vt_cnt_q  <= {VT_W{1'b0}};
            av_cnt_q  <= {AV_W{1'b0}};
            pending_q <= 1'b0;
            req_q     <= 1'b0;
            en_q      <= 1'b0;
            m_data_q  <= 32'd0;
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            en_q    <= en_cfg;
            done_q  <= 1'b0;
            words_q <= words_d;
            if (accept) begin
                m_valid_q <= 1'b0;
            end
            // The response window spans both request phases, so capture is decoupled from the state
            if (capture) begin
                m_data_q  <= trng_data;
                m_valid_q <= 1'b1;
                pending_q <= 1'b0;
            end else if (pending_q) begin
                vt_cnt_q <= vt_cnt_q + VT_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        len_q     <= burst_len;
                        words_q   <= {CNT_W{1'b0}};
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b1;
                        av_cnt_q  <= {AV_W{1'b0}};
                        state_q   <= (burst_len == {CNT_W{1'b0}}) ? S_FIN : S_WAIT_AVAIL;
                    end
                end
                S_WAIT_AVAIL: begin
                    if (!trng_fifo_empty) begin
                        req_q     <= 1'b1;
                        pending_q <= 1'b1;
                        vt_cnt_q  <= {VT_W{1'b0}};
                        hi_cnt_q  <= {HI_W{1'b0}};
                        state_q   <= S_REQ_HIGH;
                    end else if ((AVAIL_TIMEOUT != 0) && (av_cnt_q == AV_LAST)) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_FIN;
                    end else begin
                        av_cnt_q <= av_cnt_q + AV_W'(1);
                    end
                end
                S_REQ_HIGH: begin
                    if (vt_expired) begin
                        timeout_q <= 1'b1;
                        req_q     <= 1'b0;
                        pending_q <= 1'b0;
                        state_q   <= S_FIN;
                    end else if (hi_cnt_q == HI_LAST) begin
                        req_q    <= 1'b0;
                        lo_cnt_q <= {LO_W{1'b0}};
                        state_q  <= S_REQ_LOW;
                    end else begin
                        hi_cnt_q <= hi_cnt_q + HI_W'(1);
                    end
                end
                S_REQ_LOW: begin
                    if (vt_expired) begin
                        timeout_q <= 1'b1;
                        pending_q <= 1'b0;
                        state_q   <= S_FIN;
                    end else if (lo_cnt_q == LO_LAST) begin
                        if (!pending_q) begin
                            state_q <= S_HOLD;
                        end
                    end else begin
                        lo_cnt_q <= lo_cnt_q + LO_W'(1);
                    end
                end
                S_HOLD: begin
                    // The word may already have been accepted while the request was still pacing low
                    if (!m_valid_q || accept) begin
                        av_cnt_q <= {AV_W{1'b0}};
                        state_q  <= (words_d == len_q) ? S_FIN : S_WAIT_AVAIL;
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign trng_enable   = en_q;
    assign trng_read_req = req_q;
    assign m_data        = m_data_q;
    assign m_valid       = m_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign timeout_err   = timeout_q;
    assign words_done    = words_q;

endmodule
